// File: rtl/squarewave_trace_gen_if.sv
// Sample/pixel bus of the square-wave trace renderer.
// pix_grid exists only when SQW_GRID_EN is defined.
interface squarewave_trace_gen_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              smp_valid;
    logic [NUM_CH-1:0] smp_data;
    logic              smp_ready;
    logic              frame_tick;
    logic              pix_valid;
    logic [9:0]        pix_x;
    logic [9:0]        pix_y;
    logic              out_valid;
    logic              pix_on;
    logic [CH_W-1:0]   pix_ch;
`ifdef SQW_GRID_EN
    logic              pix_grid;
`endif

    modport master (
        output smp_valid, smp_data, frame_tick, pix_valid, pix_x, pix_y,
        input  smp_ready, out_valid, pix_on, pix_ch
`ifdef SQW_GRID_EN
        , input pix_grid
`endif
    );

    modport slave (
        input  smp_valid, smp_data, frame_tick, pix_valid, pix_x, pix_y,
        output smp_ready, out_valid, pix_on, pix_ch
`ifdef SQW_GRID_EN
        , output pix_grid
`endif
    );
endinterface

// File: rtl/squarewave_trace_gen.sv
// Multi-channel square-wave trace renderer: sample ring with per-frame window snapshot,
// 2-cycle pixel pipeline. Define SQW_GRID_EN to add the dotted tile-grid output pix_grid.
module squarewave_trace_gen #(
    parameter int NUM_CH      = 4,
    parameter int NUM_BITS    = 10,
    parameter int DEPTH       = 16,
    parameter int TILE_W      = 64,
    parameter int TILE_H      = 8,
    parameter int TRACE_PITCH = 16,
    parameter int Y_BASE      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    squarewave_trace_gen_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SLACK = DEPTH - NUM_BITS - 1;
    localparam int ACC_W = $clog2(SLACK + 1);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int R_W   = (TILE_H > 1) ? $clog2(TILE_H) : 1;
    localparam int X_SH  = $clog2(TILE_W);
    localparam int Y_SH  = $clog2(TRACE_PITCH);

    function automatic logic trace_lit(input logic cur, input logic prev,
                                       input logic c0, input logic [R_W-1:0] r);
        return (cur & (r == '0)) | (~cur & (r == R_W'(TILE_H - 1))) | (c0 & (cur ^ prev));
    endfunction

    logic [NUM_CH-1:0] r_ring [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_base;
    logic [ACC_W-1:0]  r_acc_cnt;
    logic              r_ready;

    logic              w_wr;
    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [ACC_W-1:0]  w_acc_nxt;

    always_comb begin
        w_wr         = bus.smp_valid & r_ready;
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_wr);
        if (bus.frame_tick) begin
            w_acc_nxt = '0;
        end else begin
            w_acc_nxt = r_acc_cnt + ACC_W'(w_wr);
        end
    end

    // A write in the tick cycle is already counted in w_wr_ptr_nxt, so it becomes the newest tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ring[i] <= '0;
            end
            r_wr_ptr  <= '0;
            r_base    <= '0;
            r_acc_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_ring[r_wr_ptr] <= bus.smp_data;
            end
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_acc_cnt <= w_acc_nxt;
            r_ready   <= (w_acc_nxt < ACC_W'(SLACK));
            if (bus.frame_tick) begin
                r_base <= w_wr_ptr_nxt - PTR_W'(NUM_BITS + 1);
            end
        end
    end

    // ---- stage 0: coordinate decode ----
    logic signed [10:0] w_dy_p0;
    logic [9:0]         w_k_p0;
    logic [9:0]         w_ch_p0;
    logic [9:0]         w_r_p0;
    logic               w_c0_p0;
    logic               w_in_p0;

    always_comb begin
        w_dy_p0 = $signed({1'b0, bus.pix_y}) - $signed(11'(Y_BASE));
        w_k_p0  = bus.pix_x >> X_SH;
        w_c0_p0 = ((bus.pix_x & 10'(TILE_W - 1)) == '0);
        w_ch_p0 = w_dy_p0[9:0] >> Y_SH;
        w_r_p0  = w_dy_p0[9:0] & 10'(TRACE_PITCH - 1);
        // Sign bit of dy rejects rows above the first trace instead of letting them wrap.
        w_in_p0 = bus.pix_valid & ~w_dy_p0[10]
                & (w_ch_p0 < 10'(NUM_CH))
                & (w_r_p0  < 10'(TILE_H))
                & (w_k_p0  < 10'(NUM_BITS));
    end

    // ---- stage 1 registers ----
    logic             r_vld_p1;
    logic             r_in_p1;
    logic [PTR_W-1:0] r_k_p1;
    logic             r_c0_p1;
    logic [CH_W-1:0]  r_ch_p1;
    logic [R_W-1:0]   r_r_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p1 <= 1'b0;
            r_in_p1  <= 1'b0;
            r_k_p1   <= '0;
            r_c0_p1  <= 1'b0;
            r_ch_p1  <= '0;
            r_r_p1   <= '0;
        end else begin
            r_vld_p1 <= bus.pix_valid;
            r_in_p1  <= w_in_p0;
            r_k_p1   <= w_in_p0 ? w_k_p0[PTR_W-1:0] : '0;
            r_c0_p1  <= w_c0_p0;
            r_ch_p1  <= w_in_p0 ? w_ch_p0[CH_W-1:0] : '0;
            r_r_p1   <= w_in_p0 ? w_r_p0[R_W-1:0] : '0;
        end
    end

    // ---- stage 1 -> 2: ring lookup and lit test ----
    logic [PTR_W-1:0] w_cur_idx;
    logic [PTR_W-1:0] w_prev_idx;
    logic             w_cur;
    logic             w_prev;
    logic             w_lit;

    always_comb begin
        w_prev_idx = r_base + r_k_p1;
        w_cur_idx  = w_prev_idx + PTR_W'(1);
        w_cur      = r_ring[w_cur_idx][r_ch_p1];
        w_prev     = r_ring[w_prev_idx][r_ch_p1];
        w_lit      = trace_lit(w_cur, w_prev, r_c0_p1, r_r_p1);
    end

    // ---- stage 2 registers (outputs) ----
    logic            r_vld_p2;
    logic            r_on_p2;
    logic [CH_W-1:0] r_ch_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2 <= 1'b0;
            r_on_p2  <= 1'b0;
            r_ch_p2  <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            r_on_p2  <= r_in_p1 & w_lit;
            r_ch_p2  <= (r_in_p1 & w_lit) ? r_ch_p1 : '0;
        end
    end

`ifdef SQW_GRID_EN
    logic r_grid_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grid_p2 <= 1'b0;
        end else begin
            r_grid_p2 <= r_in_p1 & r_c0_p1 & ~r_r_p1[0];
        end
    end

    assign bus.pix_grid = r_grid_p2;
`endif

    assign bus.smp_ready = r_ready;
    assign bus.out_valid = r_vld_p2;
    assign bus.pix_on    = r_on_p2;
    assign bus.pix_ch    = r_ch_p2;
endmodule

// File: tb/tb_squarewave_trace_gen.sv
// Self-checking bench: window-of-last-samples reference model plus hand-computed pixel probes.
module tb_squarewave_trace_gen;
    localparam int NCH   = 4;
    localparam int NB    = 10;
    localparam int DEPTH = 16;
    localparam int TW    = 64;
    localparam int TH    = 8;
    localparam int PITCH = 16;
    localparam int YB    = 32;
    localparam int SLACK = DEPTH - NB - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    squarewave_trace_gen_if #(.NUM_CH(NCH)) bus();

    squarewave_trace_gen #(
        .NUM_CH(NCH), .NUM_BITS(NB), .DEPTH(DEPTH), .TILE_W(TW),
        .TILE_H(TH), .TRACE_PITCH(PITCH), .Y_BASE(YB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int on_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the display window is simply the last NB+1 accepted samples at the latest tick.
    bit                mdl_live = 1'b0;
    bit                exp_vld, exp_on, exp_grid, exp_ready;
    int                exp_ch;
    bit                p1_v;
    int                p1_x, p1_y;
    int                cnt;
    logic [NCH-1:0]    win [NB+1];
    logic [NCH-1:0]    hist[$];

    function automatic void eval(input bit v, input int x, input int y,
                                 output bit on, output int ch, output bit grid);
        int k, c, dy, t, r;
        bit cur, prev, lit;
        on = 0; ch = 0; grid = 0;
        if (!v || y < YB) return;
        dy = y - YB; t = dy / PITCH; r = dy % PITCH; k = x / TW; c = x % TW;
        if (t >= NCH || r >= TH || k >= NB) return;
        cur  = win[k+1][t];
        prev = win[k][t];
        lit  = (cur && r == 0) || (!cur && r == TH - 1) || (c == 0 && cur != prev);
        on   = lit;
        ch   = lit ? t : 0;
        grid = (c == 0) && (r % 2 == 0);
    endfunction

    function automatic void snapshot();
        int idx;
        for (int j = 0; j <= NB; j++) begin
            idx = hist.size() - (NB + 1) + j;
            win[j] = (idx >= 0) ? hist[idx] : '0;
        end
    endfunction

    always @(posedge clk) begin
        bit acc, on_n, grid_n;
        int ch_n;
        mdl_live = 1'b1;
        if (rst) begin
            exp_vld = 0; exp_on = 0; exp_ch = 0; exp_grid = 0; exp_ready = 0;
            p1_v = 0; p1_x = 0; p1_y = 0; cnt = 0;
            hist.delete();
            for (int j = 0; j <= NB; j++) win[j] = '0;
        end else begin
            eval(p1_v, p1_x, p1_y, on_n, ch_n, grid_n);
            exp_vld = p1_v; exp_on = on_n; exp_ch = ch_n; exp_grid = grid_n;
            p1_v = bus.pix_valid; p1_x = int'(bus.pix_x); p1_y = int'(bus.pix_y);
            acc = bus.smp_valid && exp_ready;
            if (acc) begin
                hist.push_back(bus.smp_data);
                if (hist.size() > 64) void'(hist.pop_front());
            end
            if (bus.frame_tick) begin
                snapshot();
                cnt = 0;
            end else if (acc) begin
                cnt++;
            end
            exp_ready = (cnt < SLACK);
        end
    end

    always @(negedge clk) begin
        if (mdl_live) begin
            chk("out_valid", int'(bus.out_valid), int'(exp_vld));
            chk("pix_on",    int'(bus.pix_on),    int'(exp_on));
            chk("pix_ch",    int'(bus.pix_ch),    exp_ch);
            chk("smp_ready", int'(bus.smp_ready), int'(exp_ready));
`ifdef SQW_GRID_EN
            chk("pix_grid",  int'(bus.pix_grid),  int'(exp_grid));
`endif
            if (bus.out_valid && bus.pix_on) on_cnt++;
        end
    end

    task automatic probe(input int x, input int y, output int on, output int ch, output int grid);
        bus.pix_valid = 1'b1;
        bus.pix_x     = 10'(x);
        bus.pix_y     = 10'(y);
        @(negedge clk);
        bus.pix_valid = 1'b0;
        @(negedge clk);
        on = int'(bus.pix_on);
        ch = int'(bus.pix_ch);
`ifdef SQW_GRID_EN
        grid = int'(bus.pix_grid);
`else
        grid = 0;
`endif
    endtask

    task automatic lit_probe(input string name, input int x, input int y,
                             input int e_on, input int e_ch);
        int on, ch, grid;
        probe(x, y, on, ch, grid);
        chk({name, "_on"}, on, e_on);
        chk({name, "_ch"}, ch, e_ch);
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int on, ch, grid;
        bit hold_wr;
        rst = 1'b1;
        bus.smp_valid = 0; bus.smp_data = '0; bus.frame_tick = 0;
        bus.pix_valid = 0; bus.pix_x = '0; bus.pix_y = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", int'(bus.smp_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_pix_on", int'(bus.pix_on), 0);
        @(negedge clk);
        chk("ready_after_rst", int'(bus.smp_ready), 1);

        // Empty ring: only the low line of trace 0 is drawn across the sweep.
        on_cnt = 0;
        for (int y = YB; y < YB + TH; y++) begin
            for (int x = 0; x < 640; x++) begin
                bus.pix_valid = 1'b1; bus.pix_x = 10'(x); bus.pix_y = 10'(y);
                @(negedge clk);
            end
        end
        bus.pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("sweep_on_count", on_cnt, 640);
        lit_probe("flat_low", 0, YB + 7, 1, 0);
        lit_probe("flat_top", 0, YB, 0, 0);
        lit_probe("flat_mid", 100, YB + 7, 1, 0);

        // Samples 1 then 0 on channel 0.
        bus.smp_valid = 1'b1; bus.smp_data = 4'b0001; @(negedge clk);
        bus.smp_data = 4'b0000; @(negedge clk);
        bus.smp_valid = 1'b0;
        tick();
        lit_probe("t9_low", 600, YB + 7, 1, 0);
        lit_probe("t9_top", 600, YB, 0, 0);
        lit_probe("fall_edge", 576, YB + 3, 1, 0);
        lit_probe("t8_high", 540, YB, 1, 0);
        lit_probe("t8_bottom", 540, YB + 7, 0, 0);
        lit_probe("rise_edge", 512, YB + 3, 1, 0);
        lit_probe("above_trace", 600, YB - 1, 0, 0);

        // Write coinciding with frame_tick is the newest sample of the new frame.
        bus.smp_valid = 1'b1; bus.smp_data = 4'b0100; bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.smp_valid = 1'b0; bus.frame_tick = 1'b0;
        lit_probe("ch2_high", 600, YB + 32, 1, 2);
        lit_probe("ch2_edge", 576, YB + 38, 1, 2);
        lit_probe("ch0_t7_high", 460, YB, 1, 0);
        lit_probe("ch0_t9_low", 600, YB + 7, 1, 0);

        // Back-to-back offers: only SLACK accepted before the next tick.
        for (int i = 0; i < 8; i++) begin
            bus.smp_valid = 1'b1; bus.smp_data = 4'($urandom);
            chk("burst_ready", int'(bus.smp_ready), (i < SLACK) ? 1 : 0);
            @(negedge clk);
        end
        bus.smp_valid = 1'b0;
        chk("ready_held_low", int'(bus.smp_ready), 0);
        @(negedge clk);
        chk("ready_still_low", int'(bus.smp_ready), 0);
        tick();
        chk("ready_after_tick", int'(bus.smp_ready), 1);

        // 40 alternating samples across 8 frames so pointers wrap several times.
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < SLACK; i++) begin
                bus.smp_valid = 1'b1;
                bus.smp_data  = ((f * SLACK + i) % 2 == 1) ? 4'hF : 4'h0;
                @(negedge clk);
            end
            bus.smp_valid = 1'b0;
            tick();
        end
        lit_probe("wrap_t9_high", 600, YB, 1, 0);
        lit_probe("wrap_t9_low", 600, YB + 7, 0, 0);
        lit_probe("wrap_rise", 576, YB + 4, 1, 0);
        lit_probe("wrap_t8_low", 520, YB + 7, 1, 0);
        lit_probe("wrap_fall", 512, YB + 2, 1, 0);
        lit_probe("wrap_ch3", 600, YB + 48, 1, 3);
        lit_probe("wrap_t0_edge", 0, YB + 3, 1, 0);

`ifdef SQW_GRID_EN
        probe(128, YB + 2, on, ch, grid);
        chk("grid_even", grid, 1);
        probe(128, YB + 3, on, ch, grid);
        chk("grid_odd", grid, 0);
        probe(130, YB + 2, on, ch, grid);
        chk("grid_offcol", grid, 0);
`endif

        // Randomised traffic with a mid-run reset; writes wait for a tick after reset.
        hold_wr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                rst = 1'b1;
                hold_wr = 1'b1;
            end else if (i == 1503) begin
                rst = 1'b0;
            end
            bus.frame_tick = ($urandom_range(0, 39) == 0);
            bus.smp_valid  = (!hold_wr || (bus.frame_tick && !rst)) && ($urandom_range(0, 2) == 0);
            if (bus.frame_tick && !rst) hold_wr = 1'b0;
            bus.smp_data   = 4'($urandom);
            bus.pix_valid  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) begin
                bus.pix_x = 10'($urandom);
                bus.pix_y = 10'($urandom);
            end else begin
                bus.pix_x = 10'($urandom_range(0, 700));
                bus.pix_y = 10'($urandom_range(20, 110));
            end
            @(negedge clk);
        end
        bus.smp_valid = 1'b0; bus.frame_tick = 1'b0; bus.pix_valid = 1'b0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/squarewave_trace_gen.md
Name: squarewave_trace_gen

Overview:
Parametrised multi-channel square-wave trace renderer for the VGA pixel pipeline. It buffers incoming per-channel logic samples in a ring and snapshots the display window once per frame, so a frame never tears. For each pixel coordinate it produces a pixel-on flag with a fixed 2-cycle latency. Each sample occupies one tile: a level line, plus a vertical edge when the level changes.

Parameters:
NUM_CH, 4, number of traces (channels), ≥1
NUM_BITS, 10, samples shown per trace (tiles across)
DEPTH, 16, ring entries per channel; power of 2, ≥ NUM_BITS+2
TILE_W, 64, pixels per sample horizontally; power of 2
TILE_H, 8, trace height in pixel rows; power of 2
TRACE_PITCH, 16, vertical distance between trace tops; power of 2, ≥ TILE_H
Y_BASE, 32, pixel row of the top of trace 0

Ports:
clk  in  1  pixel clock
rst  in  1  synchronous reset, active-high
smp_valid  in  1  sample offered
smp_data  in  NUM_CH  one bit per channel
smp_ready  out  1  sample accepted when valid & ready
frame_tick  in  1  one-cycle pulse at frame start (vsync edge)
pix_valid  in  1  pixel coordinate valid (video_on)
pix_x  in  10  pixel column
pix_y  in  10  pixel row
out_valid  out  1  pix_valid delayed 2 cycles
pix_on  out  1  trace pixel lit
pix_ch  out  clog2(NUM_CH) (min 1)  channel of the lit pixel; 0 when pix_on=0

Behaviour:
- Reset: every ring entry=0, wr_ptr=0, base=0, acc_cnt=0, smp_ready=0 during rst and 1 on the first cycle after; pix_on=0, pix_ch=0, out_valid=0, pipeline registers cleared.
- Write: on smp_valid & smp_ready, store smp_data at ring[wr_ptr]; wr_ptr+1 mod DEPTH; acc_cnt+1.
- Flow control: SLACK = DEPTH-NUM_BITS-1. smp_ready = (acc_cnt < SLACK). When acc_cnt reaches SLACK, ready drops and writes are held off until the next frame_tick. With the defaults, at most 5 samples are accepted per frame.
- Frame snapshot: on frame_tick, base = (wr_ptr_next - NUM_BITS - 1) mod DEPTH and acc_cnt = 0. wr_ptr_next includes any write accepted in the same cycle, so a simultaneous write belongs to the new frame and is its newest sample. Because smp_ready is held to SLACK writes per frame, writes during a frame never touch the displayed entries.
- Indexing: displayed tile k (0 = leftmost and oldest, NUM_BITS-1 = newest). cur = ring[(base+1+k) mod DEPTH], prev = ring[(base+k) mod DEPTH]. All index arithmetic wraps modulo DEPTH.
- Stage 1 (registered):
  - k = pix_x / TILE_W; c = pix_x mod TILE_W.
  - dy = pix_y - Y_BASE; ch = dy / TRACE_PITCH; r = dy mod TRACE_PITCH.
  - in_area = pix_valid & pix_y ≥ Y_BASE & ch < NUM_CH & r < TILE_H & k < NUM_BITS.
- Stage 2 (registered):
  - Read cur and prev for channel ch.
  - lit = (cur & r==0) | (!cur & r==TILE_H-1) | (c==0 & cur!=prev).
  - pix_on = in_area & lit; pix_ch = lit ? ch : 0.
- out_valid follows pix_valid with 2-cycle latency. Both stages run every cycle; there is no stall.
- base changes only on frame_tick, so a coordinate in flight when frame_tick arrives may see the new base. Frame_tick lands in blanking, so this is acceptable.
- Coordinates outside every trace, including pix_y < Y_BASE (no wrap of dy), give pix_on=0.
- rst mid-frame: ring cleared, all traces render flat low from the next cycle.

Optional Feature:
SQW_GRID_EN
- Defined: adds output pix_grid (1 bit, same 2-cycle latency, reset 0). It is high when in_area & c==0 & r is even, giving a dotted tile-boundary grid. pix_grid never alters pix_on.
- Undefined: no pix_grid port and no grid logic.

Test Plan:
- Reset, no samples, sweep trace-0 rows Y_BASE..Y_BASE+7 at x=0..639 → pix_on only at row Y_BASE+7; no vertical edge; out_valid lags pix_valid by exactly 2 cycles.
- Write samples 1,0 on channel 0 (others 0), then frame_tick → tile 9 lit at row Y_BASE+7 except column 576 fully lit (rows Y_BASE..Y_BASE+7, fall edge); tile 8 lit on row Y_BASE; column 512 fully lit (rise edge); pix_ch=0.
- Hold smp_valid=1 for 8 cycles between two frame_ticks → exactly 5 accepted; smp_ready low from the cycle after the 5th until the frame_tick; acc_cnt clears on the tick.
- frame_tick and smp_valid (ch2=1) in the same cycle → next frame's tile 9 on trace 2 is high (row Y_BASE+32 lit across x 576..639).
- Push 40 alternating samples over several frames so wr_ptr and base wrap past DEPTH → every tile shows an edge at c=0, with levels alternating correctly across the wrap.
- With SQW_GRID_EN, pixel (x=128, y=Y_BASE+2) → pix_grid=1; (x=128, y=Y_BASE+3) → 0; (x=130, y=Y_BASE+2) → 0.
